pc_sequencer: RTL

//  Owns the program counter and schedules the single shared 32-bit pc_adder between

---
 rtl/pc_sequencer_pkg.sv | 32 +++
 rtl/pc_sequencer_if.sv | 38 +++
 rtl/pc_sequencer_adder.sv | 24 ++
 rtl/pc_sequencer.sv | 102 ++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg
//   Shared definitions for the program-counter sequencer:
//   - FSM state encodings (FETCH / BRANCH_CALC / HOLD)
//   - default reset vector and sequential step
//   - word-alignment mask plus small alignment helpers
//   - branch operand latch record
package pc_sequencer_pkg;

  localparam logic [1:0] ST_FETCH       = 2'd0;
  localparam logic [1:0] ST_BRANCH_CALC = 2'd1;
  localparam logic [1:0] ST_HOLD        = 2'd2;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_STEP_DEF      = 32'd4;
  localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;

  // Operands captured when a taken branch is resolved.
  typedef struct packed {
    logic [31:0] base;
    logic [31:0] offset;
  } br_op_t;

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return a & ALIGN_MASK;
  endfunction

  // Takes only the low address bits; anything non-zero there is off-word.
  function automatic logic misaligned(input logic [1:0] lo);
    return |lo;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
//   Bundles the fetch handshake and the redirect/control bus of the sequencer.
//   master : the sequencer side (drives pc_out, pc_valid, busy, misalign)
//   slave  : the surrounding pipeline / imem side
//   Signals:
//     fetch_ready    imem accepts pc_out this cycle
//     stall          hold pc, suppress fetch
//     branch_req     1-cycle taken-branch pulse, with branch_base/branch_offset
//     jump_req       1-cycle absolute redirect pulse, with jump_target
//     pc_out         current fetch address (word aligned)
//     pc_valid       pc_out is a live fetch request
//     busy           adder owned by a branch calculation
//     misalign       1-cycle pulse: redirect target had non-zero [1:0]
interface pc_sequencer_if;
  logic        fetch_ready;
  logic        stall;
  logic        branch_req;
  logic [31:0] branch_base;
  logic [31:0] branch_offset;
  logic        jump_req;
  logic [31:0] jump_target;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic        busy;
  logic        misalign;

  modport master (
    input  fetch_ready, stall, branch_req, branch_base, branch_offset,
           jump_req, jump_target,
    output pc_out, pc_valid, busy, misalign
  );

  modport slave (
    output fetch_ready, stall, branch_req, branch_base, branch_offset,
           jump_req, jump_target,
    input  pc_out, pc_valid, busy, misalign
  );
endinterface

// File: rtl/pc_sequencer_adder.sv
// pc_sequencer_adder
//   The shared pc adder: W-bit ripple-carry, modulo 2^W (carry-out dropped).
//   Ports: a, b (operands), sum (a + b mod 2^W).
module pc_sequencer_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  // cin[i] is the carry into bit i; the carry out of the MSB is never built.
  logic [W-1:0] cin;

  assign cin[0] = 1'b0;

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign sum[gi] = a[gi] ^ b[gi] ^ cin[gi];
    if (gi < W-1) begin : g_carry
      assign cin[gi+1] = (a[gi] & b[gi]) | (cin[gi] & (a[gi] ^ b[gi]));
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Owns the program counter and time-shares one 32-bit adder between the
//   sequential increment (pc + PC_STEP) and branch targets (base + offset).
//   Presents fetch addresses with a valid/ready handshake.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  pc_sequencer_if.master (fetch handshake + redirect/control)
//   Priority per cycle: rst > jump_req > branch_req > stall > fetch.
//   Branch: request cycle -> BRANCH_CALC cycle (busy) -> target on pc_out.
//   Jump:   target on pc_out the cycle after jump_req.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] PC_STEP      = PC_STEP_DEF
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.master bus
);

  logic [1:0]  state;
  logic [31:0] pc;
  br_op_t      br_q;

  logic [31:0] add_a, add_b, add_sum;
  logic        in_calc;
  logic        fetch_hs;

  assign in_calc = (state == ST_BRANCH_CALC);

  // Operand mux: BRANCH_CALC owns the adder outright, otherwise it is
  // parked on the sequential pair.
  always_comb begin
    add_a = pc;
    add_b = PC_STEP;
    if (in_calc) begin
      add_a = br_q.base;
      add_b = br_q.offset;
    end
  end

  pc_sequencer_adder #(.W(32)) u_pc_adder (
    .a   (add_a),
    .b   (add_b),
    .sum (add_sum)
  );

  // A redirect in the same cycle pre-empts the fetch, so no address is
  // offered (and no increment can happen) while one is being taken.
  always_comb begin
    bus.pc_valid = !rst && (state == ST_FETCH) && !bus.stall
                   && !bus.branch_req && !bus.jump_req;
    fetch_hs     = bus.pc_valid && bus.fetch_ready;
    bus.busy     = !rst && in_calc;
    // Misalign reports the target actually written this cycle: a jump's,
    // or the branch sum unless a fresh branch_req supersedes it.
    bus.misalign = 1'b0;
    if (!rst) begin
      if (bus.jump_req)
        bus.misalign = misaligned(bus.jump_target[1:0]);
      else if (in_calc && !bus.branch_req)
        bus.misalign = misaligned(add_sum[1:0]);
    end
  end

  assign bus.pc_out = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_VECTOR;
      state <= ST_FETCH;
      br_q  <= '0;
    end else if (bus.jump_req) begin
      // Also cancels any branch sitting in BRANCH_CALC.
      pc    <= align_pc(bus.jump_target);
      state <= bus.stall ? ST_HOLD : ST_FETCH;
    end else if (bus.branch_req) begin
      br_q.base   <= bus.branch_base;
      br_q.offset <= bus.branch_offset;
      state       <= ST_BRANCH_CALC;
    end else begin
      case (state)
        ST_BRANCH_CALC: begin
          pc    <= align_pc(add_sum);
          state <= bus.stall ? ST_HOLD : ST_FETCH;
        end
        ST_HOLD: begin
          // Leave HOLD with the same pc so the stalled address is re-offered.
          if (!bus.stall) state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (bus.stall)     state <= ST_HOLD;
          else if (fetch_hs) pc    <= add_sum;
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule
